// File: rtl/cpu_pc_ctrl_pkg.sv
// Branch opcode encoding shared by the instruction decoder and the PC/branch stage.
package cpu_pc_ctrl_pkg;
  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JC   = 3'd2;
  localparam logic [2:0] OP_JZ   = 3'd3;
  localparam logic [2:0] OP_JB   = 3'd4;
  localparam logic [2:0] OP_JNZ  = 3'd5;
  localparam logic [2:0] OP_CALL = 3'd6;
  localparam logic [2:0] OP_RET  = 3'd7;
endpackage

// File: rtl/cpu_ret_stack.sv
// LIFO return-address stack; SP counts 0..STACK_DEPTH, DOUT is the combinational top entry.
module cpu_ret_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PUSH,
  input  logic              POP,
  input  logic [ADDR_W-1:0] DIN,
  output logic [ADDR_W-1:0] DOUT,
  output logic              FULL,
  output logic              EMPTY
);
  localparam int IW = $clog2(STACK_DEPTH);

  logic [IW:0]       r_sp;
  logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
  logic [IW-1:0]     w_top;
  logic              w_push;
  logic              w_pop;

  assign FULL   = (r_sp == (IW+1)'(STACK_DEPTH));
  assign EMPTY  = (r_sp == '0);
  assign w_push = PUSH && !FULL;
  assign w_pop  = POP && !EMPTY;
  // With SP==0 this index wraps; the value is unused because pops are blocked.
  assign w_top  = IW'(r_sp - 1'b1);
  assign DOUT   = r_mem[w_top];

  always_ff @(posedge CLK) begin
    if (RST)         r_sp <= '0;
    else if (w_push) r_sp <= r_sp + 1'b1;
    else if (w_pop)  r_sp <= r_sp - 1'b1;
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge CLK) begin
    if (!RST && w_push) r_mem[r_sp[IW-1:0]] <= DIN;
  end
endmodule

// File: rtl/cpu_pc_ctrl.sv
// Program counter and branch control: next-PC mux, TAKEN strobe, sticky stack-error flags.
module cpu_pc_ctrl
  import cpu_pc_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RST_ADDR    = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [2:0]        OP,
  input  logic [ADDR_W-1:0] TARGET,
  input  logic              C,
  input  logic              Z,
  input  logic              B,
  output logic [ADDR_W-1:0] PC,
  output logic              TAKEN,
  output logic              STK_OVF,
  output logic              STK_UNF
);
  logic [ADDR_W-1:0] r_pc;
  logic              r_taken;
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_take;
  logic              w_push;
  logic              w_pop;

  // Wraps modulo 2^ADDR_W; the same value is pushed as the return address.
  assign w_pc_inc = r_pc + 1'b1;
  assign w_push   = EN && (OP == OP_CALL) && !w_full;
  assign w_pop    = EN && (OP == OP_RET) && !w_empty;

  cpu_ret_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stk (
    .CLK   (CLK),
    .RST   (RST),
    .PUSH  (w_push),
    .POP   (w_pop),
    .DIN   (w_pc_inc),
    .DOUT  (w_dout),
    .FULL  (w_full),
    .EMPTY (w_empty)
  );

  always_comb begin
    w_take   = 1'b0;
    w_pc_nxt = TARGET;
    case (OP)
      OP_JMP:  w_take = 1'b1;
      OP_JC:   w_take = C;
      OP_JZ:   w_take = Z;
      OP_JB:   w_take = B;
      OP_JNZ:  w_take = !Z;
      OP_CALL: w_take = !w_full;
      OP_RET:  begin w_take = !w_empty; w_pc_nxt = w_dout; end
      default: w_take = 1'b0;
    endcase
    if (!w_take) w_pc_nxt = w_pc_inc;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc    <= ADDR_W'(RST_ADDR);
      r_taken <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (EN) begin
      r_pc    <= w_pc_nxt;
      r_taken <= w_take;
      if (OP == OP_CALL && w_full)  r_ovf <= 1'b1;
      if (OP == OP_RET  && w_empty) r_unf <= 1'b1;
    end else begin
      r_taken <= 1'b0;
    end
  end

  assign PC      = r_pc;
  assign TAKEN   = r_taken;
  assign STK_OVF = r_ovf;
  assign STK_UNF = r_unf;
endmodule

// File: tb/tb_cpu_pc_ctrl.sv
// Scoreboarded bench for cpu_pc_ctrl: a behavioural model queues expected state per edge.
module tb_cpu_pc_ctrl;
  logic       CLK = 1'b0;
  logic       RST, EN, C, Z, B;
  logic [2:0] OP;
  logic [7:0] TARGET;
  logic [7:0] PC;
  logic       TAKEN, STK_OVF, STK_UNF;

  typedef struct packed {
    logic [7:0] pc;
    logic       tk;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_stk[$];
  logic [7:0] m_pc;
  logic       m_tk, m_ovf, m_unf;
  int         n_vec = 0;
  int         n_err = 0;

  cpu_pc_ctrl #(.ADDR_W(8), .STACK_DEPTH(4), .RST_ADDR(0)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .OP(OP), .TARGET(TARGET),
    .C(C), .Z(Z), .B(B), .PC(PC), .TAKEN(TAKEN),
    .STK_OVF(STK_OVF), .STK_UNF(STK_UNF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit en, input logic [2:0] op,
                      input logic [7:0] tgt, input bit c = 0, input bit z = 0, input bit b = 0);
    exp_t       e;
    bit         jump;
    logic [7:0] dest;
    @(negedge CLK);
    RST = rst; EN = en; OP = op; TARGET = tgt; C = c; Z = z; B = b;
    if (rst) begin
      m_pc = 8'h00; m_tk = 0; m_ovf = 0; m_unf = 0; m_stk.delete();
    end else if (!en) begin
      m_tk = 0;
    end else begin
      jump = 0; dest = tgt;
      case (op)
        3'd1: jump = 1;
        3'd2: jump = c;
        3'd3: jump = z;
        3'd4: jump = b;
        3'd5: jump = !z;
        3'd6: if (m_stk.size() == 4) m_ovf = 1;
              else begin m_stk.push_back(m_pc + 8'd1); jump = 1; end
        3'd7: if (m_stk.size() == 0) m_unf = 1;
              else begin dest = m_stk.pop_back(); jump = 1; end
        default: jump = 0;
      endcase
      m_tk = jump;
      m_pc = jump ? dest : m_pc + 8'd1;
    end
    e = '{pc: m_pc, tk: m_tk, ovf: m_ovf, unf: m_unf};
    sb.push_back(e);
    @(posedge CLK); #1;
    e = sb.pop_front();
    chk("pc",    PC,      e.pc);
    chk("taken", TAKEN,   e.tk);
    chk("ovf",   STK_OVF, e.ovf);
    chk("unf",   STK_UNF, e.unf);
  endtask

  initial begin
    RST = 1; EN = 0; OP = 0; TARGET = 0; C = 0; Z = 0; B = 0;
    step(1, 1, 3'd1, 8'h55);
    chk("rst_pc", PC, 8'h00);

    for (int i = 0; i < 5; i++) step(0, 1, 3'd0, 8'h00);
    chk("next5", PC, 8'h05);
    step(1, 1, 3'd0, 8'h00);
    chk("rst_mid", PC, 8'h00);

    for (int i = 0; i < 3; i++) step(0, 1, 3'd0, 8'h00);
    step(0, 1, 3'd2, 8'h40, 0, 0, 0);
    chk("jc_nt", PC, 8'h04);
    step(0, 1, 3'd2, 8'h40, 1, 0, 0);
    chk("jc_t", {TAKEN, PC}, 9'h140);
    step(0, 1, 3'd3, 8'h20, 0, 1, 0);
    chk("jz_t", PC, 8'h20);
    step(0, 1, 3'd5, 8'h60, 0, 1, 0);
    chk("jnz_nt", {TAKEN, PC}, 9'h021);
    step(0, 1, 3'd4, 8'h10, 0, 0, 1);
    chk("jb_t", PC, 8'h10);

    step(0, 1, 3'd1, 8'h05);
    step(0, 1, 3'd6, 8'h30);
    step(0, 1, 3'd6, 8'h50);
    chk("call2", PC, 8'h50);
    step(0, 1, 3'd7, 8'h00);
    chk("ret1", {TAKEN, PC}, 9'h131);
    step(0, 1, 3'd7, 8'h00);
    chk("ret2", {TAKEN, PC}, 9'h106);

    for (int i = 0; i < 4; i++) step(0, 1, 3'd6, 8'h80 + 8'(i * 16));
    step(0, 1, 3'd6, 8'hC0);
    chk("ovf_pc", {STK_OVF, TAKEN, PC}, 10'h2B1);
    for (int i = 0; i < 4; i++) step(0, 1, 3'd7, 8'h00);
    chk("ret4", PC, 8'h07);
    step(0, 1, 3'd7, 8'h00);
    chk("unf_pc", {STK_UNF, TAKEN, PC}, 10'h208);
    step(0, 1, 3'd0, 8'h00);
    chk("sticky", {STK_OVF, STK_UNF}, 2'b11);

    step(0, 1, 3'd1, 8'hFF);
    step(0, 1, 3'd0, 8'h00);
    chk("wrap", PC, 8'h00);
    step(0, 0, 3'd1, 8'h77);
    chk("stall", {TAKEN, PC}, 9'h000);
    step(0, 1, 3'd1, 8'hFF);
    step(0, 1, 3'd6, 8'h30);
    step(0, 1, 3'd7, 8'h00);
    chk("call_wrap", {TAKEN, PC}, 9'h100);

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    step(1, 1, 3'd0, 8'h00);
    chk("rst_flags", {STK_OVF, STK_UNF, TAKEN}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
